// File: rtl/mdio_multi_master.sv
// Clause 22 MDIO master serving PORTS independent management buses from one
// command interface; one register read or write per command.
`timescale 1ns/1ps
module mdio_multi_master #(
  parameter int PORTS        = 1,
  parameter int CLK_DIV      = 25,
  parameter int PREAMBLE_LEN = 32,
  parameter int PORT_W       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [PORT_W-1:0] cmd_port_i,
  input  logic [4:0]        cmd_phy_addr_i,
  input  logic [4:0]        cmd_reg_addr_i,
  input  logic [15:0]       cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [15:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic [PORTS-1:0]  mdc_o,
  output logic [PORTS-1:0]  mdio_out_o,
  output logic [PORTS-1:0]  mdio_oen_o,
  input  logic [PORTS-1:0]  mdio_in_i
);
  localparam int CNT_MAX = 2 * CLK_DIV - 1;
  localparam int CNT_W   = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_FIN, S_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       bit_cnt;
  logic [PORTS-1:0] sel;
  logic             write_q;
  logic [31:0]      tx;
  logic [15:0]      rd_sh;
  logic             ta_err;

  logic             port_ok;
  logic [PORTS-1:0] new_sel;
  logic             in_bit;
  logic [31:0]      frame;

  assign port_ok = {1'b0, cmd_port_i} < (PORT_W + 1)'(PORTS);
  assign new_sel = port_ok ? (PORTS'(1) << cmd_port_i) : '0;
  assign in_bit  = |(mdio_in_i & sel);
  assign busy_o  = ~cmd_ready_o;

  // ST, OP, PHYAD, REGAD, TA, DATA; read TA/DATA are ones so the released pad idles high
  assign frame = {2'b01, cmd_write_i ? 2'b01 : 2'b10, cmd_phy_addr_i, cmd_reg_addr_i,
                  cmd_write_i ? 2'b10 : 2'b11, cmd_write_i ? cmd_wdata_i : 16'hFFFF};

  function automatic logic [PORTS-1:0] pad_out(input logic b, input logic [PORTS-1:0] s);
    return b ? {PORTS{1'b1}} : ~s;
  endfunction

  function automatic logic [PORTS-1:0] pad_oen(input logic en, input logic [PORTS-1:0] s);
    return en ? s : '0;
  endfunction

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      mdc_o       <= '0;
      mdio_out_o  <= '1;
      mdio_oen_o  <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            sel         <= new_sel;
            write_q     <= cmd_write_i;
            tx          <= frame;
            cnt         <= '0;
            if (!port_ok) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end else if (PREAMBLE_LEN > 0) begin
              state      <= S_PRE;
              bit_cnt    <= 6'(PREAMBLE_LEN - 1);
              mdio_out_o <= pad_out(1'b1, new_sel);
              mdio_oen_o <= new_sel;
            end else begin
              state      <= S_HDR;
              bit_cnt    <= 6'd13;
              mdio_out_o <= pad_out(1'b0, new_sel);
              mdio_oen_o <= new_sel;
            end
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          cmd_ready_o <= 1'b1;
        end
        default: begin
          if (cnt == CNT_W'(CNT_MAX)) begin
            // bit boundary: MDC falls and the next bit goes onto the pad together
            cnt   <= '0;
            mdc_o <= '0;
            if (state inside {S_HDR, S_TA, S_DATA}) tx <= {tx[30:0], 1'b1};
            case (state)
              S_PRE: begin
                if (bit_cnt == 6'd0) begin
                  state      <= S_HDR;
                  bit_cnt    <= 6'd13;
                  mdio_out_o <= pad_out(tx[31], sel);
                end else begin
                  bit_cnt    <= bit_cnt - 1'b1;
                  mdio_out_o <= pad_out(1'b1, sel);
                end
                mdio_oen_o <= sel;
              end
              S_HDR: begin
                if (bit_cnt == 6'd0) begin
                  state      <= S_TA;
                  bit_cnt    <= 6'd1;
                  mdio_oen_o <= pad_oen(write_q, sel);
                end else begin
                  bit_cnt    <= bit_cnt - 1'b1;
                  mdio_oen_o <= sel;
                end
                mdio_out_o <= pad_out(tx[30], sel);
              end
              S_TA: begin
                if (bit_cnt == 6'd0) begin
                  state   <= S_DATA;
                  bit_cnt <= 6'd15;
                end else begin
                  bit_cnt <= bit_cnt - 1'b1;
                end
                mdio_out_o <= pad_out(tx[30], sel);
                mdio_oen_o <= pad_oen(write_q, sel);
              end
              S_DATA: begin
                if (bit_cnt == 6'd0) begin
                  state      <= S_FIN;
                  mdio_out_o <= '1;
                  mdio_oen_o <= '0;
                end else begin
                  bit_cnt    <= bit_cnt - 1'b1;
                  mdio_out_o <= pad_out(tx[30], sel);
                  mdio_oen_o <= pad_oen(write_q, sel);
                end
              end
              S_FIN: begin
                state       <= S_RESP;
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= write_q ? 16'h0000 : rd_sh;
                rsp_err_o   <= write_q ? 1'b0 : ta_err;
                mdio_out_o  <= '1;
                mdio_oen_o  <= '0;
              end
              default: state <= S_IDLE;
            endcase
          end else begin
            cnt <= cnt + 1'b1;
            // last low-phase cycle: MDC rises next and the pad is sampled now
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
              mdc_o <= sel;
              if (state == S_TA && bit_cnt == 6'd0) ta_err <= in_bit;
              if (state == S_DATA) rd_sh <= {rd_sh[14:0], in_bit};
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_multi_master.sv
// Bench for mdio_multi_master: two-port default-timing instance with a PHY
// responder and response scoreboard, plus a fast no-preamble instance.
`timescale 1ns/1ps
module tb_mdio_multi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [1:0]  cmd_port = '0;
  logic [4:0]  cmd_phy = '0, cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;
  logic [1:0]  mdc, mdio_out, mdio_oen;
  logic [1:0]  mdio_in = 2'b11;

  mdio_multi_master #(.PORTS(2), .CLK_DIV(25), .PREAMBLE_LEN(32), .PORT_W(2)) dut (
    .clk_i(clk), .srst_i(srst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_write_i(cmd_write), .cmd_port_i(cmd_port), .cmd_phy_addr_i(cmd_phy),
    .cmd_reg_addr_i(cmd_reg), .cmd_wdata_i(cmd_wdata), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .busy_o(busy), .mdc_o(mdc),
    .mdio_out_o(mdio_out), .mdio_oen_o(mdio_oen), .mdio_in_i(mdio_in));

  logic        f_valid = 1'b0, f_write = 1'b0;
  logic [0:0]  f_port = '0;
  logic [4:0]  f_phy = '0, f_reg = '0;
  logic [15:0] f_wdata = '0;
  logic        f_ready, f_rsp_valid, f_rsp_err, f_busy;
  logic [15:0] f_rdata;
  logic [0:0]  f_mdc, f_out, f_oen;
  logic [0:0]  f_in = 1'b1;

  mdio_multi_master #(.PORTS(1), .CLK_DIV(2), .PREAMBLE_LEN(0)) dut_fast (
    .clk_i(clk), .srst_i(srst), .cmd_valid_i(f_valid), .cmd_ready_o(f_ready),
    .cmd_write_i(f_write), .cmd_port_i(f_port), .cmd_phy_addr_i(f_phy),
    .cmd_reg_addr_i(f_reg), .cmd_wdata_i(f_wdata), .rsp_valid_o(f_rsp_valid),
    .rsp_rdata_o(f_rdata), .rsp_err_o(f_rsp_err), .busy_o(f_busy), .mdc_o(f_mdc),
    .mdio_out_o(f_out), .mdio_oen_o(f_oen), .mdio_in_i(f_in));

  typedef struct {
    logic        write;
    logic [1:0]  port;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic        phy_on;
    logic [15:0] phy_data;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          t_acc;
  } sb_t;

  sb_t exp_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // PHY responder and serial capture of the active port
  int          act_port = -1;
  logic        phy_on = 1'b0;
  logic [15:0] phy_data = '0;
  logic [64:0] cap = '0, capoen = '0;
  int          ncap = 0, viol = 0;
  logic [1:0]  prev_mdc = '0;
  logic        rsp_pend = 1'b0;

  function automatic logic phy_bit(input int r);
    if (!phy_on) return 1'b1;
    if (r == 47) return 1'b0;
    if (r >= 48 && r <= 63) return phy_data[63 - r];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rsp_pend) begin
      chk("ready_after_rsp", 128'(cmd_ready), 128'(1));
      chk("rsp_one_cycle", 128'(rsp_valid), 128'(0));
      rsp_pend = 1'b0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%0h expected no response", rsp_rdata);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
        chk("rsp_err", 128'(rsp_err), 128'(e.err));
        chk("rsp_latency", 128'(cyc - e.t_acc), 128'(e.lat));
        chk("ready_low_at_rsp", 128'(cmd_ready), 128'(0));
        rsp_pend = 1'b1;
      end
    end
    if (cmd_valid && cmd_ready) begin
      cap = '0; capoen = '0; ncap = 0; viol = 0; mdio_in = 2'b11;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (p != act_port) begin
          if (mdc[p] || mdio_oen[p] || !mdio_out[p]) viol++;
        end else begin
          if (mdc[p] && !prev_mdc[p]) begin
            cap    = {cap[63:0], mdio_oen[p] ? mdio_out[p] : mdio_in[p]};
            capoen = {capoen[63:0], mdio_oen[p]};
            ncap++;
          end
          if (!mdc[p] && prev_mdc[p]) mdio_in[p] = phy_bit(ncap);
        end
      end
    end
    prev_mdc = mdc;
  end

  task automatic issue(input logic w, input logic [1:0] port, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd, output int t);
    @(posedge clk); #1;
    chk("ready_before_cmd", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1; cmd_write = w; cmd_port = port;
    cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd;
    t = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_phy = ~phy; cmd_reg = ~rg; cmd_wdata = ~wd; cmd_write = ~w;
  endtask

  task automatic run_cmd(input vec_t v);
    int t;
    sb_t e;
    logic [64:0] es, eo;
    act_port = (v.port < 2'd2) ? int'(v.port) : -1;
    phy_on   = v.phy_on;
    phy_data = v.phy_data;
    issue(v.write, v.port, v.phy, v.regad, v.wdata, t);
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat; e.t_acc = t;
    exp_q.push_back(e);
    if (act_port >= 0) begin
      repeat (100) @(posedge clk);
      #1 cmd_valid = 1'b1; cmd_port = 2'd3;
      @(posedge clk); #1 cmd_valid = 1'b0;
    end
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no response, expected one within 4000 cycles");
      exp_q.delete();
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_after_done", 128'(busy), 128'(0));
    chk("idle_ports_quiet", 128'(viol), 128'(0));
    if (act_port >= 0) begin
      if (v.write) begin
        es = {32'hFFFF_FFFF, 4'b0101, v.phy, v.regad, 2'b10, v.wdata, 1'b1};
        eo = {64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      end else begin
        es = {32'hFFFF_FFFF, 4'b0110, v.phy, v.regad, 1'b1, !v.phy_on,
              v.phy_on ? v.phy_data : 16'hFFFF, 1'b1};
        eo = {46'h3FFF_FFFF_FFFF, 19'h0};
      end
      chk("mdc_bit_count", 128'(ncap), 128'(65));
      chk("serial_stream", 128'(cap), 128'(es));
      chk("oen_per_bit", 128'(capoen), 128'(eo));
    end
  endtask

  vec_t vecs[5];

  initial begin
    int t, lat;
    logic [7:0]  mdc_pat;
    logic [32:0] fs, fo;
    vec_t last;

    vecs[0] = '{1'b1, 2'd1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, 16'h0000, 1'b0, 3251};
    vecs[1] = '{1'b0, 2'd0, 5'h03, 5'h02, 16'h0000, 1'b1, 16'h796D, 16'h796D, 1'b0, 3251};
    vecs[2] = '{1'b1, 2'd3, 5'h07, 5'h09, 16'hDEAD, 1'b0, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[3] = '{1'b0, 2'd1, 5'h1F, 5'h1F, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 3251};
    vecs[4] = '{1'b0, 2'd0, 5'h10, 5'h05, 16'h0000, 1'b1, 16'hA5C3, 16'hA5C3, 1'b0, 3251};

    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    chk("rst_ready", 128'(cmd_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rdata", 128'(rsp_rdata), 128'(0));
    chk("rst_err", 128'(rsp_err), 128'(0));
    chk("rst_mdc", 128'(mdc), 128'(0));
    chk("rst_out", 128'(mdio_out), 128'(2'b11));
    chk("rst_oen", 128'(mdio_oen), 128'(0));

    // fast instance: no preamble, 4-cycle MDC
    @(posedge clk); #1;
    chk("fast_ready", 128'(f_ready), 128'(1));
    f_valid = 1'b1; f_write = 1'b1; f_port = 1'b0; f_phy = 5'h05; f_reg = 5'h0A; f_wdata = 16'h1234;
    @(posedge clk); #1;
    f_valid = 1'b0; f_wdata = 16'h0000;
    mdc_pat = '0; fs = '0; fo = '0; lat = -1;
    for (int j = 1; j <= 140; j++) begin
      if (j <= 8) mdc_pat = {mdc_pat[6:0], f_mdc[0]};
      if ((j - 1) % 4 == 0 && j <= 132) begin
        fs = {fs[31:0], f_oen[0] ? f_out[0] : f_in[0]};
        fo = {fo[31:0], f_oen[0]};
      end
      if (f_rsp_valid && lat < 0) begin
        lat = j;
        chk("fast_rdata", 128'(f_rdata), 128'(0));
        chk("fast_err", 128'(f_rsp_err), 128'(0));
      end
      @(posedge clk); #1;
    end
    chk("fast_mdc_pattern", 128'(mdc_pat), 128'(8'b0011_0011));
    chk("fast_stream", 128'(fs), 128'({4'b0101, 5'h05, 5'h0A, 2'b10, 16'h1234, 1'b1}));
    chk("fast_oen", 128'(fo), 128'({32'hFFFF_FFFF, 1'b0}));
    chk("fast_latency", 128'(lat), 128'(133));
    chk("fast_ready_after", 128'(f_ready), 128'(1));

    for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

    // reset in the middle of a write, during DATA bit 5
    act_port = 0; phy_on = 1'b0;
    issue(1'b1, 2'd0, 5'h02, 5'h04, 16'hBEEF, t);
    for (int i = 0; i < 4000 && ncap < 54; i++) @(posedge clk);
    chk("reached_data_bit5", 128'(ncap >= 54), 128'(1));
    #1 srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0;
    chk("mid_rst_ready", 128'(cmd_ready), 128'(1));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("mid_rst_rdata", 128'(rsp_rdata), 128'(0));
    chk("mid_rst_err", 128'(rsp_err), 128'(0));
    chk("mid_rst_mdc", 128'(mdc), 128'(0));
    chk("mid_rst_out", 128'(mdio_out), 128'(2'b11));
    chk("mid_rst_oen", 128'(mdio_oen), 128'(0));
    repeat (300) @(posedge clk);
    #1 chk("no_rsp_after_rst", 128'(exp_q.size()), 128'(0));

    last = '{1'b1, 2'd1, 5'h0C, 5'h11, 16'h0F0F, 1'b0, 16'h0000, 16'h0000, 1'b0, 3251};
    run_cmd(last);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before 2000000 ns");
    $fatal(1, "watchdog");
  end
endmodule
